// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32M funct3 codes, multiply/divide FSM encoding, iteration count
package riscv_pkg;

  localparam int unsigned WORD_BITWIDTH_DEFAULT = 32;
  localparam int unsigned ITER_COUNT = WORD_BITWIDTH_DEFAULT;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_div_step.sv
// rtl/mdu_div_step.sv - one restoring-division step: shift in next dividend bit, trial subtract
module mdu_div_step #(
  parameter int unsigned WORD_BITWIDTH = 32
) (
  input  logic [WORD_BITWIDTH-1:0] i_rem,
  input  logic [WORD_BITWIDTH-1:0] i_quo,
  input  logic [WORD_BITWIDTH-1:0] i_divisor,
  output logic [WORD_BITWIDTH-1:0] o_rem,
  output logic [WORD_BITWIDTH-1:0] o_quo
);

  logic [WORD_BITWIDTH:0] w_shift;
  logic                   w_ge;

  assign w_shift = {i_rem, i_quo[WORD_BITWIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, i_divisor});
  // The true difference is below the divisor, so modulo-2^W subtraction is exact.
  assign o_rem   = w_ge ? (w_shift[WORD_BITWIDTH-1:0] - i_divisor) : w_shift[WORD_BITWIDTH-1:0];
  assign o_quo   = {i_quo[WORD_BITWIDTH-2:0], w_ge};

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - RV32M iterative multiply/divide unit (shift-add multiply, restoring divide)
// Divide support is built only when MUL_DIV_UNIT_DIV_EN is defined; otherwise divide ops flag illegal_op.
module mul_div_unit
  import riscv_pkg::*;
#(
  parameter int unsigned WORD_BITWIDTH = WORD_BITWIDTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2:0]               funct3,
  input  logic [WORD_BITWIDTH-1:0] operand_a,
  input  logic [WORD_BITWIDTH-1:0] operand_b,
  output logic                     busy,
  output logic                     done,
  output logic [WORD_BITWIDTH-1:0] result,
  output logic                     illegal_op
);

  localparam int unsigned W     = WORD_BITWIDTH;
  localparam int unsigned CNT_W = $clog2(ITER_COUNT);

  mdu_state_e       r_state, w_state_next;
  logic [2:0]       r_funct3;
  logic [2*W-1:0]   r_acc;
  logic [W-1:0]     r_mag;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_lo, r_neg_hi;
  logic [W-1:0]     r_result;

  logic             w_sa, w_sb, w_last;
  logic [W-1:0]     w_abs_a, w_abs_b;
  logic [W:0]       w_mul_sum;
  logic [2*W-1:0]   w_mul_next, w_prod_fix;
  logic [W-1:0]     w_quo_fix, w_rem_fix, w_final;

  always_comb begin
    w_sa = 1'b0;
    w_sb = 1'b0;
    case (funct3)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
        w_sa = operand_a[W-1];
        w_sb = operand_b[W-1];
      end
      F3_MULHSU: w_sa = operand_a[W-1];
      F3_MULHU, F3_DIVU, F3_REMU: ;
      default: ;
    endcase
  end

  assign w_abs_a = w_sa ? -operand_a : operand_a;
  assign w_abs_b = w_sb ? -operand_b : operand_b;
  assign w_last  = (r_cnt == CNT_W'(ITER_COUNT - 1));

  // Upper half accumulates the multiplicand, lower half holds the multiplier being consumed.
  assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_mag} : {(W+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

  assign w_prod_fix = r_neg_lo ? -r_acc : r_acc;
  assign w_quo_fix  = r_neg_lo ? -r_acc[W-1:0] : r_acc[W-1:0];
  assign w_rem_fix  = r_neg_hi ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];

  always_comb begin
    w_final = w_rem_fix;
    case (r_funct3)
      F3_MUL:                       w_final = w_prod_fix[W-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_final = w_prod_fix[2*W-1:W];
      F3_DIV, F3_DIVU:              w_final = w_quo_fix;
      F3_REM, F3_REMU:              w_final = w_rem_fix;
      default:                      w_final = w_rem_fix;
    endcase
  end

`ifdef MUL_DIV_UNIT_DIV_EN
  logic         r_fast;
  logic         w_div_zero, w_div_ovf;
  logic [W-1:0] w_rem_next, w_quo_next;

  assign w_div_zero = (operand_b == '0);
  assign w_div_ovf  = w_sa && w_sb && (operand_a == {1'b1, {(W-1){1'b0}}}) && (operand_b == '1);

  mdu_div_step #(.WORD_BITWIDTH(W)) u_div_step (
    .i_rem     (r_acc[2*W-1:W]),
    .i_quo     (r_acc[W-1:0]),
    .i_divisor (r_mag),
    .o_rem     (w_rem_next),
    .o_quo     (w_quo_next)
  );

  assign illegal_op = 1'b0;
`else
  logic r_illegal;

  assign illegal_op = (r_state == ST_DONE) && r_illegal;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
`ifdef MUL_DIV_UNIT_DIV_EN
          w_state_next = funct3[2] ? ST_DIV : ST_MUL;
`else
          w_state_next = funct3[2] ? ST_DONE : ST_MUL;
`endif
        end
      end
      ST_MUL: if (w_last) w_state_next = ST_DONE;
`ifdef MUL_DIV_UNIT_DIV_EN
      ST_DIV: if (r_fast || w_last) w_state_next = ST_DONE;
`else
      ST_DIV: w_state_next = ST_IDLE;
`endif
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_funct3 <= '0;
      r_acc    <= '0;
      r_mag    <= '0;
      r_cnt    <= '0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_result <= '0;
`ifdef MUL_DIV_UNIT_DIV_EN
      r_fast   <= 1'b0;
`else
      r_illegal <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_funct3 <= funct3;
            r_cnt    <= '0;
            r_neg_hi <= 1'b0;
            if (!funct3[2]) begin
              r_acc    <= {{W{1'b0}}, w_abs_b};
              r_mag    <= w_abs_a;
              r_neg_lo <= w_sa ^ w_sb;
`ifdef MUL_DIV_UNIT_DIV_EN
              r_fast   <= 1'b0;
`else
              r_illegal <= 1'b0;
`endif
            end else begin
`ifdef MUL_DIV_UNIT_DIV_EN
              // Fast-path answers are preloaded so DONE reads them like a finished divide.
              r_neg_lo <= 1'b0;
              r_fast   <= w_div_zero || w_div_ovf;
              r_mag    <= w_abs_b;
              if (w_div_zero) begin
                r_acc <= {operand_a, {W{1'b1}}};
              end else if (w_div_ovf) begin
                r_acc <= {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};
              end else begin
                r_acc    <= {{W{1'b0}}, w_abs_a};
                r_neg_lo <= w_sa ^ w_sb;
                r_neg_hi <= w_sa;
              end
`else
              r_acc     <= '0;
              r_mag     <= '0;
              r_neg_lo  <= 1'b0;
              r_illegal <= 1'b1;
`endif
            end
          end
        end
        ST_MUL: begin
          r_acc <= w_mul_next;
          r_cnt <= r_cnt + 1'b1;
        end
`ifdef MUL_DIV_UNIT_DIV_EN
        ST_DIV: begin
          if (!r_fast) begin
            r_acc <= {w_rem_next, w_quo_next};
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        ST_DONE: r_result <= w_final;
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != ST_IDLE);
  assign done   = (r_state == ST_DONE);
  assign result = (r_state == ST_DONE) ? w_final : r_result;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed and random checks of mul_div_unit against an arithmetic reference
// Expectations for divide ops follow MUL_DIV_UNIT_DIV_EN as seen by this compile.
module tb_mul_div_unit;
  import riscv_pkg::*;

`ifdef MUL_DIV_UNIT_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        busy, done, illegal_op;
  logic [31:0] result;

  int n_assert = 0;
  int n_fail   = 0;

  mul_div_unit #(.WORD_BITWIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .funct3     (funct3),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    int          ia, ib;
    bit          ovf;
    sa  = longint'(signed'(a));
    sb  = longint'(signed'(b));
    ia  = signed'(a);
    ib  = signed'(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      F3_MUL:    begin p = sa * sb; return p[31:0]; end
      F3_MULH:   begin p = sa * sb; return p[63:32]; end
      F3_MULHSU: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      F3_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      F3_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : ia / ib;
      F3_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F3_REM:    return (b == 0) ? a : ovf ? 32'h0 : ia % ib;
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 33;
    if (!DIV_EN) return 1;
    if (b == 0) return 2;
    if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 33;
  endfunction

  // Called at a falling edge; returns at the falling edge of the cycle after done.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_in, input bit poke, input string tag);
    logic [31:0] exp_res, res_at_done;
    int          exp_lat, done_cyc;
    bit          exp_ill, ill_at_done, busy_at_done, busy_gap;
    exp_ill      = f3[2] && !DIV_EN;
    exp_res      = exp_ill ? 32'h0 : exp_in;
    exp_lat      = exp_latency(f3, a, b);
    done_cyc     = 0;
    busy_gap     = 1'b0;
    res_at_done  = '0;
    ill_at_done  = 1'b0;
    busy_at_done = 1'b0;
    start = 1'b1; funct3 = f3; operand_a = a; operand_b = b;
    @(posedge clk);
    for (int cyc = 1; cyc <= 40 && done_cyc == 0; cyc++) begin
      @(negedge clk);
      if (done) begin
        done_cyc = cyc; res_at_done = result; ill_at_done = illegal_op; busy_at_done = busy;
      end else if (!busy) begin
        busy_gap = 1'b1;
      end
      if (cyc == 1) begin
        start = 1'b0; funct3 = 3'($urandom); operand_a = $urandom; operand_b = $urandom;
      end
      if (poke && cyc == 5) start = 1'b1;
      if (poke && cyc == 6) start = 1'b0;
    end
    check({tag, "_latency"}, 32'(done_cyc), 32'(exp_lat));
    check({tag, "_result"}, res_at_done, exp_res);
    check({tag, "_illegal"}, {31'b0, ill_at_done}, {31'b0, exp_ill});
    check({tag, "_busy"}, {30'b0, busy_gap, busy_at_done}, 32'd1);
    @(negedge clk);
    check({tag, "_idle_after"}, {29'b0, busy, done, illegal_op}, 32'd0);
    check({tag, "_hold"}, result, exp_res);
  endtask

  initial begin
    bit          saw_done;
    logic [2:0]  f3;
    logic [31:0] a, b;

    repeat (2) @(negedge clk);
    check("reset_flags", {29'b0, busy, done, illegal_op}, 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b0;

    run_op(F3_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1, "mul_7_m3");
    run_op(F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, "mulh_min");
    run_op(F3_MULHU,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, "mulhu_min");
    run_op(F3_MULHSU, 32'h8000_0000, 32'd2,         32'hFFFF_FFFF, 1'b0, "mulhsu_min2");
    run_op(F3_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, "div_m7_2");
    run_op(F3_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, "rem_m7_2");
    run_op(F3_DIVU,   32'd100,       32'd7,         32'd14,        1'b0, "divu_100_7");
    run_op(F3_REMU,   32'd100,       32'd7,         32'd2,         1'b0, "remu_100_7");
    run_op(F3_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, "divu_by0");
    run_op(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, "rem_ovf");
    run_op(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, "div_ovf");
    run_op(F3_REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1'b0, "rem_by0");
    run_op(F3_MUL,    32'd3,         32'd5,         32'd15,        1'b0, "mul_3_5");

    start = 1'b1; funct3 = F3_MUL; operand_a = 32'd9; operand_b = 32'd11;
    saw_done = 1'b0;
    @(posedge clk);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
      if (cyc == 1) start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("rst_abort_flags", {29'b0, busy, done, illegal_op}, 32'd0);
    check("rst_abort_result", result, 32'd0);
    @(posedge clk);
    @(negedge clk);
    if (done) saw_done = 1'b1;
    rst = 1'b0;
    check("rst_no_done", {30'b0, saw_done, busy}, 32'd0);
    @(negedge clk);
    run_op(F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul_after_rst");

    for (int i = 0; i < 24; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if (i % 5 == 0) b = 32'd0;
      if (i % 7 == 3) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (i % 6 == 1) b = 32'($urandom_range(1, 300));
      run_op(f3, a, b, ref_model(f3, a, b), (i % 4 == 0), $sformatf("rand%0d_f%0d", i, f3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
